// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encodings
// and the shift-amount width helper.
package shifter_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_SLL = 3'b000;
  localparam logic [OP_W-1:0] OP_SRL = 3'b001;
  localparam logic [OP_W-1:0] OP_SRA = 3'b010;
  localparam logic [OP_W-1:0] OP_ROL = 3'b011;
  localparam logic [OP_W-1:0] OP_ROR = 3'b100;

  // One shift layer per shamt bit; never below one bit so ports stay legal.
  function automatic int shamt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One barrel-shifter layer: conditional shift/rotate by 2**K, carry tracking,
// followed by the stage pipeline register (held when en is low).
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int K     = 0,
  localparam int SW   = shamt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             valid,
  input  logic [WIDTH-1:0] data,
  input  logic [SW-1:0]    shamt,
  input  logic [OP_W-1:0]  op,
  input  logic [TAG_W-1:0] tag,
  input  logic             carry,
  output logic [WIDTH-1:0] data_next,
  output logic             valid_reg,
  output logic [WIDTH-1:0] data_reg,
  output logic [SW-1:0]    shamt_reg,
  output logic [OP_W-1:0]  op_reg,
  output logic [TAG_W-1:0] tag_reg,
  output logic             carry_reg
);

  localparam int D = 2 ** K;

  logic carry_next;

  // The bit leaving the word in the last active layer is the overall carry;
  // layers with their shamt bit clear pass the previous carry through.
  always_comb begin
    data_next  = data;
    carry_next = carry;
    if (shamt[K]) begin
      case (op)
        OP_SLL: begin
          data_next  = data << D;
          carry_next = data[WIDTH-D];
        end
        OP_SRL: begin
          data_next  = data >> D;
          carry_next = data[D-1];
        end
        OP_SRA: begin
          data_next  = $unsigned($signed(data) >>> D);
          carry_next = data[D-1];
        end
        OP_ROL: begin
          data_next  = (data << D) | (data >> (WIDTH - D));
          carry_next = data[WIDTH-D];
        end
        OP_ROR: begin
          data_next  = (data >> D) | (data << (WIDTH - D));
          carry_next = data[D-1];
        end
        default: begin
          data_next  = data;
          carry_next = carry;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      shamt_reg <= '0;
      op_reg    <= '0;
      tag_reg   <= '0;
      carry_reg <= 1'b0;
    end else if (en) begin
      valid_reg <= valid;
      data_reg  <= data_next;
      shamt_reg <= shamt;
      op_reg    <= op;
      tag_reg   <= tag;
      carry_reg <= carry_next;
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined shift/rotate unit with valid/ready handshake: one register per
// shift layer, whole pipe stalls together when the output is blocked.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  localparam int SW   = shamt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SW-1:0]    in_shamt,
  input  logic [OP_W-1:0]  in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int S = SW;

  logic             adv;
  logic             zero_reg;
  logic             valid_c     [0:S];
  logic [WIDTH-1:0] data_c      [0:S];
  logic [SW-1:0]    shamt_c     [0:S];
  logic [OP_W-1:0]  op_c        [0:S];
  logic [TAG_W-1:0] tag_c       [0:S];
  logic             carry_c     [0:S];
  logic [WIDTH-1:0] data_next_c [0:S-1];

  // Bubbles are not squeezed out, so the pipe moves only when the head can.
  assign adv      = out_ready || !out_valid;
  assign in_ready = adv;

  assign valid_c[0] = in_valid;
  assign data_c[0]  = in_data;
  assign shamt_c[0] = in_shamt;
  assign op_c[0]    = in_op;
  assign tag_c[0]   = in_tag;
  assign carry_c[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < S; gi++) begin : g_stage
      shift_stage #(
        .WIDTH(WIDTH),
        .TAG_W(TAG_W),
        .K    (gi)
      ) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (adv),
        .valid    (valid_c[gi]),
        .data     (data_c[gi]),
        .shamt    (shamt_c[gi]),
        .op       (op_c[gi]),
        .tag      (tag_c[gi]),
        .carry    (carry_c[gi]),
        .data_next(data_next_c[gi]),
        .valid_reg(valid_c[gi+1]),
        .data_reg (data_c[gi+1]),
        .shamt_reg(shamt_c[gi+1]),
        .op_reg   (op_c[gi+1]),
        .tag_reg  (tag_c[gi+1]),
        .carry_reg(carry_c[gi+1])
      );
    end
  endgenerate

  // Zero flag is taken from the last layer's result and lands with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_reg <= 1'b0;
    end else if (adv) begin
      zero_reg <= (data_next_c[S-1] == '0);
    end
  end

  assign out_valid = valid_c[S];
  assign out_data  = data_c[S];
  assign out_carry = carry_c[S];
  assign out_tag   = tag_c[S];
  assign out_zero  = zero_reg;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench: table vectors, backpressure, random throughput and
// mid-flight reset on WIDTH=8, plus random sweeps on WIDTH=4 and WIDTH=64.
module tb_pipelined_barrel_shifter;
  import shifter_pkg::*;

  localparam int W  = 8;
  localparam int S  = 3;
  localparam int TW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  in_data, out_data;
  logic [S-1:0]  in_shamt;
  logic [2:0]    in_op;
  logic [TW-1:0] in_tag, out_tag;
  logic          out_carry, out_zero;
  logic          sweep_go;

  pipelined_barrel_shifter #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_carry(out_carry), .out_zero(out_zero), .out_tag(out_tag)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int stall_start = -100;
  int waits    = 0;

  typedef struct {
    logic [W-1:0]  data;
    logic          carry;
    logic          zero;
    logic [TW-1:0] tag;
    int            cyc;
  } exp_t;

  typedef struct {
    logic [W-1:0]  d;
    logic [2:0]    sh;
    logic [2:0]    op;
    logic [TW-1:0] tag;
    logic [W-1:0]  e_data;
    logic          e_carry;
    logic          e_zero;
  } vec_t;

  exp_t sb[$];
  exp_t cur_exp;
  vec_t vecs[16];

  logic          prev_stall;
  logic [W-1:0]  held_data;
  logic [TW-1:0] held_tag;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Bit-by-bit reference: {carry, data} for a width-w operation.
  function automatic logic [64:0] model(input logic [63:0] d, input int sh,
                                        input logic [2:0] op, input int w);
    logic [63:0] r;
    logic        c;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < w; i++) begin
      case (op)
        3'd0:    r[i] = (i >= sh) ? d[i-sh] : 1'b0;
        3'd1:    r[i] = (i + sh < w) ? d[i+sh] : 1'b0;
        3'd2:    r[i] = (i + sh < w) ? d[i+sh] : d[w-1];
        3'd3:    r[i] = d[(i - sh + w) % w];
        3'd4:    r[i] = d[(i + sh) % w];
        default: r[i] = d[i];
      endcase
    end
    if (sh != 0) begin
      case (op)
        3'd0:       c = d[w-sh];
        3'd1, 3'd2: c = d[sh-1];
        3'd3:       c = r[0];
        3'd4:       c = r[w-1];
        default:    c = 1'b0;
      endcase
    end
    return {c, r};
  endfunction

  // One clock: evaluate both handshakes mid-cycle, then advance to posedge+1.
  task automatic tick(output logic acc);
    logic ohs;
    exp_t e;
    out_ready = !(cyc >= stall_start && cyc < stall_start + 4);
    @(negedge clk);
    acc = in_valid && in_ready;
    ohs = out_valid && out_ready;
    if (prev_stall) begin
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_data", 64'(out_data), 64'(held_data));
      check("stall_tag", 64'(out_tag), 64'(held_tag));
    end
    if (out_valid && !out_ready) check("stall_in_ready", 64'(in_ready), 64'd0);
    prev_stall = out_valid && !out_ready;
    held_data  = out_data;
    held_tag   = out_tag;
    if (ohs) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 64'(out_tag), 64'hDEAD);
      end else begin
        e = sb.pop_front();
        $display("cyc %0d: out data=0x%02h carry=%0d zero=%0d tag=0x%0h", cyc,
                 out_data, out_carry, out_zero, out_tag);
        check("out_data", 64'(out_data), 64'(e.data));
        check("out_carry", 64'(out_carry), 64'(e.carry));
        check("out_zero", 64'(out_zero), 64'(e.zero));
        check("out_tag", 64'(out_tag), 64'(e.tag));
        if (stall_start < 0) check("latency", 64'(cyc - e.cyc), 64'(S));
      end
    end
    if (acc) begin
      e = cur_exp;
      e.cyc = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [W-1:0] d, input logic [2:0] sh, input logic [2:0] op,
                      input logic [TW-1:0] tag, input logic [W-1:0] e_data,
                      input logic e_carry, input logic e_zero);
    logic acc;
    acc = 1'b0;
    cur_exp  = '{data: e_data, carry: e_carry, zero: e_zero, tag: tag, cyc: 0};
    in_data  = d;
    in_shamt = sh;
    in_op    = op;
    in_tag   = tag;
    in_valid = 1'b1;
    for (int t = 0; t < 20 && !acc; t++) begin
      tick(acc);
      if (!acc) waits++;
    end
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input logic [TW-1:0] tag);
    logic [W-1:0] d;
    logic [2:0]   sh, op;
    logic [64:0]  m;
    d  = W'($urandom);
    sh = 3'($urandom_range(0, W - 1));
    op = 3'($urandom_range(0, 5));
    m  = model(64'(d), int'(sh), op, W);
    send(d, sh, op, tag, m[W-1:0], m[64], m[W-1:0] == '0);
  endtask

  task automatic drain();
    logic acc;
    in_valid = 1'b0;
    for (int t = 0; t < 40 && sb.size() > 0; t++) tick(acc);
    check("drain_empty", 64'(sb.size()), 64'd0);
    for (int t = 0; t < 4; t++) tick(acc);
  endtask

  initial begin
    vecs[0]  = '{8'h96, 3'd3, OP_SLL, 4'h5, 8'hB0, 1'b0, 1'b0};
    vecs[1]  = '{8'h96, 3'd2, OP_SRA, 4'h5, 8'hE5, 1'b1, 1'b0};
    vecs[2]  = '{8'h96, 3'd4, OP_ROR, 4'h5, 8'h69, 1'b0, 1'b0};
    vecs[3]  = '{8'h96, 3'd1, OP_ROL, 4'h5, 8'h2D, 1'b1, 1'b0};
    vecs[4]  = '{8'h80, 3'd7, OP_SRL, 4'h1, 8'h01, 1'b0, 1'b0};
    vecs[5]  = '{8'h01, 3'd1, OP_SRL, 4'h2, 8'h00, 1'b1, 1'b1};
    vecs[6]  = '{8'hFF, 3'd0, OP_SLL, 4'h3, 8'hFF, 1'b0, 1'b0};
    vecs[7]  = '{8'h3C, 3'd5, 3'b111, 4'h4, 8'h3C, 1'b0, 1'b0};
    vecs[8]  = '{8'h40, 3'd3, OP_SRA, 4'h6, 8'h08, 1'b0, 1'b0};
    vecs[9]  = '{8'h01, 3'd1, OP_ROR, 4'h7, 8'h80, 1'b1, 1'b0};
    vecs[10] = '{8'h80, 3'd7, OP_ROL, 4'h8, 8'h40, 1'b0, 1'b0};
    vecs[11] = '{8'h01, 3'd7, OP_SLL, 4'h9, 8'h80, 1'b0, 1'b0};
    vecs[12] = '{8'h80, 3'd7, OP_SRA, 4'hA, 8'hFF, 1'b0, 1'b0};
    vecs[13] = '{8'h00, 3'd5, OP_ROL, 4'hB, 8'h00, 1'b0, 1'b1};
    vecs[14] = '{8'hFF, 3'd0, OP_SRA, 4'hC, 8'hFF, 1'b0, 1'b0};
    vecs[15] = '{8'hA5, 3'd6, OP_SRL, 4'hD, 8'h02, 1'b1, 1'b0};

    prev_stall = 1'b0;
    held_data  = '0;
    held_tag   = '0;
    sweep_go   = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    in_data    = '0;
    in_shamt   = '0;
    in_op      = '0;
    in_tag     = '0;
    rst_n      = 1'b1;
    #2 rst_n   = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_carry", 64'(out_carry), 64'd0);
    check("rst_out_zero", 64'(out_zero), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Directed vectors, streamed back-to-back.
    for (int i = 0; i < 16; i++)
      send(vecs[i].d, vecs[i].sh, vecs[i].op, vecs[i].tag,
           vecs[i].e_data, vecs[i].e_carry, vecs[i].e_zero);
    drain();

    // Backpressure: out_ready low for 4 cycles while the pipe is full.
    waits = 0;
    stall_start = cyc + 5;
    for (int i = 0; i < 10; i++) send_rand(TW'(i));
    drain();
    stall_start = -100;
    check("bp_input_waits", 64'(waits), 64'd4);

    // Full throughput: no input cycle may be refused.
    waits = 0;
    for (int i = 0; i < 256; i++) send_rand(TW'(i));
    drain();
    check("tp_input_waits", 64'(waits), 64'd0);

    // Reset with three ops in flight.
    for (int i = 0; i < 3; i++) send_rand(TW'(i + 1));
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_data", 64'(out_data), 64'd0);
    check("midrst_out_carry", 64'(out_carry), 64'd0);
    check("midrst_out_zero", 64'(out_zero), 64'd0);
    check("midrst_out_tag", 64'(out_tag), 64'd0);
    sb.delete();
    prev_stall = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_hold_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    send(8'hF0, 3'd4, OP_SRL, 4'hE, 8'h0F, 1'b0, 1'b0);
    drain();

    // Width sweep on the side instances.
    sweep_go = 1'b1;
    for (int i = 0; i < 2000 && !(g_sweep[0].done && g_sweep[1].done); i++) @(posedge clk);
    check("sweep_done", 64'({g_sweep[0].done, g_sweep[1].done}), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sweep
      localparam int SWW = (gi == 0) ? 4 : 64;
      localparam int SWS = (gi == 0) ? 2 : 6;
      localparam int SHW = $clog2(SWW);

      typedef struct {
        logic [63:0] data;
        logic        carry;
        logic        zero;
        logic [3:0]  tag;
        int          cyc;
        bit          lat;
      } sexp_t;

      logic            v, r, ov, ir, oc, oz;
      logic [SWW-1:0]  d, od;
      logic [SHW-1:0]  sh;
      logic [2:0]      op;
      logic [3:0]      tg, otg;
      logic            done = 1'b0;
      sexp_t           q[$];

      pipelined_barrel_shifter #(.WIDTH(SWW), .TAG_W(4)) dut_sw (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v), .in_ready(ir), .in_data(d),
        .in_shamt(sh), .in_op(op), .in_tag(tg),
        .out_valid(ov), .out_ready(r), .out_data(od),
        .out_carry(oc), .out_zero(oz), .out_tag(otg)
      );

      initial begin
        int          c;
        logic [63:0] rnd;
        logic [64:0] m;
        sexp_t       e;
        c  = 0;
        v  = 1'b0;
        r  = 1'b1;
        d  = '0;
        sh = '0;
        op = '0;
        tg = '0;
        wait (sweep_go);
        @(posedge clk);
        #1;
        for (int i = 0; i < 230; i++) begin
          if (i < 200) begin
            rnd = {$urandom, $urandom};
            v   = ($urandom % 4) != 0;
            d   = rnd[SWW-1:0];
            sh  = SHW'($urandom_range(0, SWW - 1));
            op  = 3'($urandom_range(0, 7));
            tg  = 4'($urandom);
          end else begin
            v = 1'b0;
          end
          r = (i < 100 || i >= 200) ? 1'b1 : (($urandom % 3) != 0);
          @(negedge clk);
          if (ov && r) begin
            if (q.size() == 0) begin
              check($sformatf("w%0d_unexpected", SWW), 64'(otg), 64'hDEAD);
            end else begin
              e = q.pop_front();
              $display("w%0d cyc %0d: out data=0x%0h carry=%0d zero=%0d tag=0x%0h",
                       SWW, c, od, oc, oz, otg);
              check($sformatf("w%0d_data", SWW), 64'(od), e.data);
              check($sformatf("w%0d_carry", SWW), 64'(oc), 64'(e.carry));
              check($sformatf("w%0d_zero", SWW), 64'(oz), 64'(e.zero));
              check($sformatf("w%0d_tag", SWW), 64'(otg), 64'(e.tag));
              if (e.lat) check($sformatf("w%0d_latency", SWW), 64'(c - e.cyc), 64'(SWS));
            end
          end
          if (v && ir) begin
            m = model(64'(d), int'(sh), op, SWW);
            e = '{data: m[63:0], carry: m[64], zero: (m[63:0] == 64'd0),
                  tag: tg, cyc: c, lat: (i < 90)};
            q.push_back(e);
          end
          @(posedge clk);
          #1;
          c++;
        end
        check($sformatf("w%0d_drain", SWW), 64'(q.size()), 64'd0);
        done = 1'b1;
      end
    end
  endgenerate

endmodule
